mips16_alu: RTL and testbench
=============================

Name: mips16_alu

Overview:
Execute-stage ALU of the 16-bit pipelined MIPS-style processor. It takes decoded operands A and B, a 6-bit decoded opcode, and external input data. It produces a registered result, the store data for data memory, a registered output-port value, and two status flags. All outputs update on the rising clock edge, one cycle after the inputs are applied.

Parameters:
None. The width is fixed at 16 bits and the opcode at 6 bits.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; clears all outputs
data_in  in  16  external input-port data, consumed by IN
op_dec  in  6  decoded opcode
A  in  16  operand A (first source register)
B  in  16  operand B (second register, immediate, or shift amount)
ans_ex  out  16  registered ALU result, or memory address for LD/ST
DM_data  out  16  registered store data for data memory
data_out  out  16  registered output-port value
flag_ex  out  2  registered flags: [1] = carry/borrow, [0] = zero

Behaviour:
Common rules
- One clock; reset is synchronous and active-high.
- When reset=1 at a rising edge, ans_ex, DM_data, data_out and flag_ex all become 0. Reset overrides any opcode presented in the same cycle.
- Latency is exactly 1 cycle; there is no handshake, and a new op is accepted every cycle.
- Any output an opcode does not name holds its previous value.
- Arithmetic is 16-bit unsigned modulo 2^16.
- Z (zero flag) = (16-bit result == 0).

Arithmetic (C and Z update)
- 000000 ADD and 001000 ADI: ans = A+B; C = bit 16 of the sum.
- 000001 SUB and 001001 SBI: ans = A-B; C = borrow, i.e. 1 when A<B unsigned.
- 011000 CMP: computes A-B; updates C and Z only; ans_ex holds.

Logic (Z updates, C cleared)
- 000100 AND, 001100 ANI: A&B.
- 000101 OR, 001101 ORI: A|B.
- 000110 XOR, 001110 XRI: A^B.
- 000111 NOT, 001111 NTI: ~A.

Moves (flags hold)
- 000010 MOV: ans = A.
- 001010 MVI: ans = B.

Shifts and rotates (amount n = B[3:0]; C = last bit shifted out; Z updates)
- 011001 SLA: A<<n.
- 011010 SRA: A>>>n, sign-filling.
- 011011 SRL: A>>n, zero-filling.
- 011100 SLL: A<<n. Identical to SLA and kept for ISA completeness.
- 011110 ROL: rotate A left by n; C = new bit 0.
- 011111 ROR: rotate A right by n; C = new bit 15.
- n=0: ans = A and C = 0.

Memory and I/O (flags hold)
- 010100 LD: ans = B, the address.
- 010101 ST: ans = B, the address; DM_data = A.
- 010110 IN: ans = data_in.
- 010111 OUT: data_out = A.

No-ops
- 010000 RET, 010001 HLT and every unlisted opcode (000011, 001011, 010010, 010011, 011101, 1xxxxx) hold all outputs.

Decomposition:
- Shared package mips16_pkg holds:
  - an opcode localparam/enum for all codes above;
  - width constants: DATA_W=16, OP_W=6;
  - flag index constants: FLAG_C=1, FLAG_Z=0.
- One natural sub-module is mips16_shifter, a combinational block that takes A, n and the shift/rotate mode and returns the result and carry-out. The rest is a single case statement feeding the output registers.

Test Plan:
- Reset: drive reset=1 for 2 cycles with arbitrary op -> all outputs 0. Then release reset and present NOP -> outputs remain 0.
- Arithmetic, A=0x4000, B=0xC000, one op per cycle:
  - ADD -> ans 0x0000, flag 2'b11.
  - SUB -> ans 0x8000, flag 2'b10.
  - CMP -> ans holds 0x8000, flag 2'b10.
- Logic, same operands:
  - AND -> 0x4000, flag 00.
  - OR -> 0xC000.
  - XOR -> 0x8000.
  - NOT -> 0xBFFF, flag 00.
- Shifts, A=0xC000, B=0x0001:
  - SLA -> 0x8000, C=1.
  - SRA -> 0xE000, C=0.
  - SRL -> 0x6000, C=0.
  - ROL -> 0x8001, C=1.
  - ROR -> 0x6000, C=0.
  - B=0x0000 with SRL -> 0xC000, C=0.
- Memory/I/O, A=0x4000, B=0xC000, data_in=0x0008:
  - ST -> ans 0xC000, DM_data 0x4000.
  - IN -> ans 0x0008.
  - OUT -> data_out 0x4000.
  - Flags unchanged throughout.
- Hold and reset priority:
  - HLT, RET and op 6'b100000 -> all outputs unchanged from the prior cycle.
  - ADD with reset=1 in the same cycle -> all outputs 0.

Source files
------------

// File: rtl/mips16_pkg.sv
// -----------------------------------------------------------------------------
// mips16_pkg
// Shared definitions for the 16-bit MIPS-style execute stage:
//   - datapath / opcode widths and flag bit positions
//   - decoded opcode values
//   - shift/rotate mode selector used by mips16_shifter
//   - small helper for the zero flag
// -----------------------------------------------------------------------------
package mips16_pkg;

   localparam int DATA_W = 16;
   localparam int OP_W   = 6;

   // Bit positions inside flag_ex
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 0;

   // Arithmetic
   localparam logic [OP_W-1:0] OP_ADD = 6'b000000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b000001;
   localparam logic [OP_W-1:0] OP_ADI = 6'b001000;
   localparam logic [OP_W-1:0] OP_SBI = 6'b001001;
   localparam logic [OP_W-1:0] OP_CMP = 6'b011000;
   // Logic
   localparam logic [OP_W-1:0] OP_AND = 6'b000100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b000101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b000110;
   localparam logic [OP_W-1:0] OP_NOT = 6'b000111;
   localparam logic [OP_W-1:0] OP_ANI = 6'b001100;
   localparam logic [OP_W-1:0] OP_ORI = 6'b001101;
   localparam logic [OP_W-1:0] OP_XRI = 6'b001110;
   localparam logic [OP_W-1:0] OP_NTI = 6'b001111;
   // Moves
   localparam logic [OP_W-1:0] OP_MOV = 6'b000010;
   localparam logic [OP_W-1:0] OP_MVI = 6'b001010;
   // Shifts / rotates
   localparam logic [OP_W-1:0] OP_SLA = 6'b011001;
   localparam logic [OP_W-1:0] OP_SRA = 6'b011010;
   localparam logic [OP_W-1:0] OP_SRL = 6'b011011;
   localparam logic [OP_W-1:0] OP_SLL = 6'b011100;
   localparam logic [OP_W-1:0] OP_ROL = 6'b011110;
   localparam logic [OP_W-1:0] OP_ROR = 6'b011111;
   // Memory / IO
   localparam logic [OP_W-1:0] OP_LD  = 6'b010100;
   localparam logic [OP_W-1:0] OP_ST  = 6'b010101;
   localparam logic [OP_W-1:0] OP_IN  = 6'b010110;
   localparam logic [OP_W-1:0] OP_OUT = 6'b010111;
   // Control (no effect on this stage)
   localparam logic [OP_W-1:0] OP_RET = 6'b010000;
   localparam logic [OP_W-1:0] OP_HLT = 6'b010001;

   typedef enum logic [2:0] {
      SH_LEFT = 3'd0,   // SLA and SLL share one implementation
      SH_SRA  = 3'd1,
      SH_SRL  = 3'd2,
      SH_ROL  = 3'd3,
      SH_ROR  = 3'd4
   } shift_mode_t;

   function automatic logic is_zero(input logic [DATA_W-1:0] v);
      return (v == '0);
   endfunction

endpackage

// File: rtl/mips16_shifter.sv
// -----------------------------------------------------------------------------
// mips16_shifter
// Combinational shift/rotate unit.
// Ports:
//   a     in  16  value to shift
//   n     in  4   shift amount (0..15)
//   mode  in      shift_mode_t selector
//   res   out 16  shifted / rotated value
//   carry out 1   last bit shifted out (rotates: bit that wrapped); 0 when n=0
// -----------------------------------------------------------------------------
module mips16_shifter
   import mips16_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [3:0]        n,
   input  shift_mode_t       mode,
   output logic [DATA_W-1:0] res,
   output logic              carry
);

   // Shifts are done on a 17-bit word with one guard bit beyond the end the
   // data leaves from; after the shift the guard bit holds the last bit
   // shifted out, and is naturally 0 when n=0.
   logic [DATA_W:0]   left_ext;
   logic [DATA_W:0]   srl_ext;
   logic [DATA_W:0]   sra_ext;
   logic [DATA_W-1:0] rol_val;
   logic [DATA_W-1:0] ror_val;
   logic [4:0]        n_comp;

   always_comb begin
      n_comp   = 5'd16 - {1'b0, n};
      left_ext = {1'b0, a} << n;
      srl_ext  = {a, 1'b0} >> n;
      sra_ext  = $unsigned($signed({a, 1'b0}) >>> n);
      // n=0 makes n_comp=16, which shifts the wrap-around term fully out
      rol_val  = (a << n) | (a >> n_comp);
      ror_val  = (a >> n) | (a << n_comp);
   end

   always_comb begin
      res   = a;
      carry = 1'b0;
      case (mode)
         SH_LEFT: begin
            res   = left_ext[DATA_W-1:0];
            carry = left_ext[DATA_W];
         end
         SH_SRA: begin
            res   = sra_ext[DATA_W:1];
            carry = sra_ext[0];
         end
         SH_SRL: begin
            res   = srl_ext[DATA_W:1];
            carry = srl_ext[0];
         end
         SH_ROL: begin
            res   = rol_val;
            carry = (n != 4'd0) && rol_val[0];
         end
         SH_ROR: begin
            res   = ror_val;
            carry = (n != 4'd0) && ror_val[DATA_W-1];
         end
         default: begin
            res   = a;
            carry = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mips16_alu.sv
// -----------------------------------------------------------------------------
// mips16_alu
// Execute-stage ALU of the 16-bit pipelined MIPS-style core. One op per cycle,
// all outputs registered with a latency of one clock. Outputs an opcode does
// not touch keep their previous value.
// Ports:
//   clk       in  1   rising-edge clock
//   reset     in  1   synchronous active-high, clears every output
//   data_in   in  16  external input-port data (IN)
//   op_dec    in  6   decoded opcode
//   A         in  16  first source operand
//   B         in  16  second operand / immediate / shift amount / address
//   ans_ex    out 16  result, or memory address for LD/ST
//   DM_data   out 16  store data for data memory (ST)
//   data_out  out 16  output-port value (OUT)
//   flag_ex   out 2   [1] carry/borrow, [0] zero
// -----------------------------------------------------------------------------
module mips16_alu
   import mips16_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic [OP_W-1:0]   op_dec,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] ans_ex,
   output logic [DATA_W-1:0] DM_data,
   output logic [DATA_W-1:0] data_out,
   output logic [1:0]        flag_ex
);

   logic [DATA_W-1:0] ans_reg,  ans_next;
   logic [DATA_W-1:0] dm_reg,   dm_next;
   logic [DATA_W-1:0] dout_reg, dout_next;
   logic [1:0]        flag_reg, flag_next;

   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] logic_res;
   logic [DATA_W-1:0] sh_res;
   logic              sh_carry;
   shift_mode_t       sh_mode;

   // Shift mode decode; the shifter output is only used for shift opcodes.
   always_comb begin
      sh_mode = SH_LEFT;
      case (op_dec)
         OP_SRA:  sh_mode = SH_SRA;
         OP_SRL:  sh_mode = SH_SRL;
         OP_ROL:  sh_mode = SH_ROL;
         OP_ROR:  sh_mode = SH_ROR;
         default: sh_mode = SH_LEFT;
      endcase
   end

   mips16_shifter u_shifter (
      .a     (A),
      .n     (B[3:0]),
      .mode  (sh_mode),
      .res   (sh_res),
      .carry (sh_carry)
   );

   always_comb begin
      // 17-bit arithmetic: bit 16 is the carry of the sum and, for the
      // difference, the borrow (set exactly when A < B unsigned).
      sum       = {1'b0, A} + {1'b0, B};
      diff      = {1'b0, A} - {1'b0, B};
      logic_res = '0;

      ans_next  = ans_reg;
      dm_next   = dm_reg;
      dout_next = dout_reg;
      flag_next = flag_reg;

      case (op_dec)
         OP_ADD, OP_ADI: begin
            ans_next          = sum[DATA_W-1:0];
            flag_next[FLAG_C] = sum[DATA_W];
            flag_next[FLAG_Z] = is_zero(sum[DATA_W-1:0]);
         end
         OP_SUB, OP_SBI: begin
            ans_next          = diff[DATA_W-1:0];
            flag_next[FLAG_C] = diff[DATA_W];
            flag_next[FLAG_Z] = is_zero(diff[DATA_W-1:0]);
         end
         OP_CMP: begin
            flag_next[FLAG_C] = diff[DATA_W];
            flag_next[FLAG_Z] = is_zero(diff[DATA_W-1:0]);
         end
         OP_AND, OP_ANI, OP_OR, OP_ORI, OP_XOR, OP_XRI, OP_NOT, OP_NTI: begin
            // op_dec[1:0] picks the function identically for the register
            // and immediate forms
            case (op_dec[1:0])
               2'b00:   logic_res = A & B;
               2'b01:   logic_res = A | B;
               2'b10:   logic_res = A ^ B;
               default: logic_res = ~A;
            endcase
            ans_next          = logic_res;
            flag_next[FLAG_C] = 1'b0;
            flag_next[FLAG_Z] = is_zero(logic_res);
         end
         OP_MOV: ans_next = A;
         OP_MVI: ans_next = B;
         OP_SLA, OP_SLL, OP_SRA, OP_SRL, OP_ROL, OP_ROR: begin
            ans_next          = sh_res;
            flag_next[FLAG_C] = sh_carry;
            flag_next[FLAG_Z] = is_zero(sh_res);
         end
         OP_LD:  ans_next = B;
         OP_ST: begin
            ans_next = B;
            dm_next  = A;
         end
         OP_IN:  ans_next  = data_in;
         OP_OUT: dout_next = A;
         default: ; // RET, HLT and unused codes leave every output alone
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ans_reg  <= '0;
         dm_reg   <= '0;
         dout_reg <= '0;
         flag_reg <= '0;
      end else begin
         ans_reg  <= ans_next;
         dm_reg   <= dm_next;
         dout_reg <= dout_next;
         flag_reg <= flag_next;
      end
   end

   assign ans_ex   = ans_reg;
   assign DM_data  = dm_reg;
   assign data_out = dout_reg;
   assign flag_ex  = flag_reg;

endmodule

// File: tb/tb_mips16_alu.sv
// -----------------------------------------------------------------------------
// tb_mips16_alu
// Self-checking bench for mips16_alu: directed steps with hand-computed
// expectations, followed by random ops compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_mips16_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data_in;
   logic [5:0]  op_dec;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] ans_ex;
   logic [15:0] DM_data;
   logic [15:0] data_out;
   logic [1:0]  flag_ex;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [15:0] m_ans, m_dm, m_dout;
   logic [1:0]  m_flag;

   always #5 clk = ~clk;

   mips16_alu dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .op_dec   (op_dec),
      .A        (A),
      .B        (B),
      .ans_ex   (ans_ex),
      .DM_data  (DM_data),
      .data_out (data_out),
      .flag_ex  (flag_ex)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Bit-serial shift model: applies n single-bit steps, carry = last bit out.
   function automatic logic [16:0] shift_model(input int kind, input logic [15:0] a, input int n);
      logic c;
      c = 1'b0;
      for (int i = 0; i < n; i++) begin
         case (kind)
            0: begin c = a[15]; a = {a[14:0], 1'b0};  end // SLA/SLL
            1: begin c = a[0];  a = {a[15], a[15:1]}; end // SRA
            2: begin c = a[0];  a = {1'b0, a[15:1]};  end // SRL
            3: begin a = {a[14:0], a[15]}; c = a[0];  end // ROL
            default: begin a = {a[0], a[15:1]}; c = a[15]; end // ROR
         endcase
      end
      return {c, a};
   endfunction

   task automatic model(input logic [5:0] op, input logic [15:0] a, b, din, input bit rst);
      int unsigned s;
      logic [16:0] sh;
      logic [15:0] r;
      if (rst) begin
         m_ans = 0; m_dm = 0; m_dout = 0; m_flag = 0;
         return;
      end
      case (op)
         6'b000000, 6'b001000: begin
            s = int'(a) + int'(b);
            m_ans  = s[15:0];
            m_flag = {s > 32'hFFFF, s[15:0] == 0};
         end
         6'b000001, 6'b001001: begin
            m_ans  = a - b;
            m_flag = {a < b, a == b};
         end
         6'b011000: m_flag = {a < b, a == b};
         6'b000100, 6'b001100: begin r = a & b; m_ans = r; m_flag = {1'b0, r == 0}; end
         6'b000101, 6'b001101: begin r = a | b; m_ans = r; m_flag = {1'b0, r == 0}; end
         6'b000110, 6'b001110: begin r = a ^ b; m_ans = r; m_flag = {1'b0, r == 0}; end
         6'b000111, 6'b001111: begin r = ~a;    m_ans = r; m_flag = {1'b0, r == 0}; end
         6'b000010: m_ans = a;
         6'b001010: m_ans = b;
         6'b011001, 6'b011100, 6'b011010, 6'b011011, 6'b011110, 6'b011111: begin
            case (op)
               6'b011010: sh = shift_model(1, a, int'(b[3:0]));
               6'b011011: sh = shift_model(2, a, int'(b[3:0]));
               6'b011110: sh = shift_model(3, a, int'(b[3:0]));
               6'b011111: sh = shift_model(4, a, int'(b[3:0]));
               default:   sh = shift_model(0, a, int'(b[3:0]));
            endcase
            m_ans  = sh[15:0];
            m_flag = {sh[16], sh[15:0] == 0};
         end
         6'b010100: m_ans = b;
         6'b010101: begin m_ans = b; m_dm = a; end
         6'b010110: m_ans = din;
         6'b010111: m_dout = a;
         default: ;
      endcase
   endtask

   // Apply one op for one cycle, then compare every output against the model.
   task automatic step(input string tag, input logic [5:0] op, input logic [15:0] a, b, din, input bit rst);
      op_dec = op; A = a; B = b; data_in = din; reset = rst;
      model(op, a, b, din, rst);
      @(posedge clk);
      #1;
      chk({tag, ".ans"},  ans_ex,   m_ans);
      chk({tag, ".dm"},   DM_data,  m_dm);
      chk({tag, ".dout"}, data_out, m_dout);
      chk({tag, ".flag"}, {14'd0, flag_ex}, {14'd0, m_flag});
      $display("step %-8s op=%b A=%h B=%h din=%h rst=%0d -> ans=%h dm=%h dout=%h flag=%b",
               tag, op, a, b, din, rst, ans_ex, DM_data, data_out, flag_ex);
   endtask

   logic [15:0] p_ans, p_dm, p_dout;
   logic [1:0]  p_flag;

   initial begin
      reset = 1'b1; op_dec = 6'b000000; A = 16'h1234; B = 16'h5678; data_in = 16'h9ABC;

      // Reset with arbitrary ops, then NOP
      step("rst0", 6'b000000, 16'hFFFF, 16'h0001, 16'h1111, 1'b1);
      step("rst1", 6'b010111, 16'hABCD, 16'h0001, 16'h1111, 1'b1);
      chk("rst.ans", ans_ex, 16'h0000);
      chk("rst.dout", data_out, 16'h0000);
      step("nop", 6'b010000, 16'hABCD, 16'h0001, 16'h1111, 1'b0);
      chk("nop.ans", ans_ex, 16'h0000);

      // Arithmetic
      step("ADD", 6'b000000, 16'h4000, 16'hC000, 16'h0, 1'b0);
      chk("ADD.ans_k", ans_ex, 16'h0000);  chk("ADD.flag_k", {14'd0, flag_ex}, 16'd3);
      step("SUB", 6'b000001, 16'h4000, 16'hC000, 16'h0, 1'b0);
      chk("SUB.ans_k", ans_ex, 16'h8000);  chk("SUB.flag_k", {14'd0, flag_ex}, 16'd2);
      step("CMP", 6'b011000, 16'h4000, 16'hC000, 16'h0, 1'b0);
      chk("CMP.ans_k", ans_ex, 16'h8000);  chk("CMP.flag_k", {14'd0, flag_ex}, 16'd2);

      // Logic
      step("AND", 6'b000100, 16'h4000, 16'hC000, 16'h0, 1'b0);
      chk("AND.ans_k", ans_ex, 16'h4000);  chk("AND.flag_k", {14'd0, flag_ex}, 16'd0);
      step("OR",  6'b000101, 16'h4000, 16'hC000, 16'h0, 1'b0);
      chk("OR.ans_k", ans_ex, 16'hC000);
      step("XOR", 6'b000110, 16'h4000, 16'hC000, 16'h0, 1'b0);
      chk("XOR.ans_k", ans_ex, 16'h8000);
      step("NOT", 6'b000111, 16'h4000, 16'hC000, 16'h0, 1'b0);
      chk("NOT.ans_k", ans_ex, 16'hBFFF);  chk("NOT.flag_k", {14'd0, flag_ex}, 16'd0);

      // Shifts and rotates
      step("SLA", 6'b011001, 16'hC000, 16'h0001, 16'h0, 1'b0);
      chk("SLA.ans_k", ans_ex, 16'h8000);  chk("SLA.c_k", {15'd0, flag_ex[1]}, 16'd1);
      step("SRA", 6'b011010, 16'hC000, 16'h0001, 16'h0, 1'b0);
      chk("SRA.ans_k", ans_ex, 16'hE000);  chk("SRA.c_k", {15'd0, flag_ex[1]}, 16'd0);
      step("SRL", 6'b011011, 16'hC000, 16'h0001, 16'h0, 1'b0);
      chk("SRL.ans_k", ans_ex, 16'h6000);
      step("ROL", 6'b011110, 16'hC000, 16'h0001, 16'h0, 1'b0);
      chk("ROL.ans_k", ans_ex, 16'h8001);  chk("ROL.c_k", {15'd0, flag_ex[1]}, 16'd1);
      step("ROR", 6'b011111, 16'hC000, 16'h0001, 16'h0, 1'b0);
      chk("ROR.ans_k", ans_ex, 16'h6000);  chk("ROR.c_k", {15'd0, flag_ex[1]}, 16'd0);
      step("SRL0", 6'b011011, 16'hC000, 16'h0000, 16'h0, 1'b0);
      chk("SRL0.ans_k", ans_ex, 16'hC000); chk("SRL0.c_k", {15'd0, flag_ex[1]}, 16'd0);
      step("SLL15", 6'b011100, 16'h0003, 16'h000F, 16'h0, 1'b0);
      chk("SLL15.ans_k", ans_ex, 16'h8000); chk("SLL15.c_k", {15'd0, flag_ex[1]}, 16'd1);

      // Memory / IO
      p_flag = flag_ex;
      step("ST",  6'b010101, 16'h4000, 16'hC000, 16'h0008, 1'b0);
      chk("ST.ans_k", ans_ex, 16'hC000);   chk("ST.dm_k", DM_data, 16'h4000);
      step("IN",  6'b010110, 16'h4000, 16'hC000, 16'h0008, 1'b0);
      chk("IN.ans_k", ans_ex, 16'h0008);
      step("OUT", 6'b010111, 16'h4000, 16'hC000, 16'h0008, 1'b0);
      chk("OUT.dout_k", data_out, 16'h4000);
      chk("IO.flag_hold", {14'd0, flag_ex}, {14'd0, p_flag});

      // Hold opcodes
      p_ans = ans_ex; p_dm = DM_data; p_dout = data_out; p_flag = flag_ex;
      step("HLT", 6'b010001, 16'h1111, 16'h2222, 16'h3333, 1'b0);
      step("RET", 6'b010000, 16'h1111, 16'h2222, 16'h3333, 1'b0);
      step("op32", 6'b100000, 16'h1111, 16'h2222, 16'h3333, 1'b0);
      chk("hold.ans", ans_ex, p_ans);
      chk("hold.dm", DM_data, p_dm);
      chk("hold.dout", data_out, p_dout);
      chk("hold.flag", {14'd0, flag_ex}, {14'd0, p_flag});

      // Reset beats an op in the same cycle
      step("ADDrst", 6'b000000, 16'h4000, 16'h4000, 16'h0, 1'b1);
      chk("ADDrst.ans_k", ans_ex, 16'h0000);
      chk("ADDrst.flag_k", {14'd0, flag_ex}, 16'd0);

      // Random ops against the model
      for (int i = 0; i < 400; i++) begin
         logic [5:0]  r_op;
         logic [15:0] r_a, r_b;
         bit          r_rst;
         r_op  = 6'($urandom_range(0, 63));
         r_a   = 16'($urandom);
         r_b   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         if ($urandom_range(0, 7) == 0) r_b = r_a;
         r_rst = ($urandom_range(0, 39) == 0);
         step("rand", r_op, r_a, r_b, 16'($urandom), r_rst);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
